sequential_divider: RTL

Iterative signed divider: 32-bit dividend ÷ 16-bit divisor → 16-bit quotient and 16-bit remainder, one quotient bit per clock (restoring shift-subtract). It is the inverse companion of the 16×16 → 32 array multiplier in the ALU datapath. The ALU issues it through a start/done handshake, so a divide occupies the unit for a fixed number of cycles while the rest of the ALU stays combinational.

---
 rtl/sequential_divider_if.sv | 23 ++
 rtl/sequential_divider.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sequential_divider_if.sv
// Start/done handshake bundle between the ALU issue logic and the iterative divider.
// The master issues operands; the slave returns registered results and status.
interface sequential_divider_if;
  logic               start;
  logic signed [31:0] dividend;
  logic signed [15:0] divisor;
  logic signed [15:0] quotient;
  logic signed [15:0] remainder;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic               overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/sequential_divider.sv
// Iterative signed 32/16 restoring divider, one quotient bit per clock, truncating toward zero.
// Magnitudes are divided unsigned and the signs are restored in a single fix-up cycle.
module sequential_divider (
  input  logic              clk,
  input  logic              rst,
  sequential_divider_if.slave bus
);
  localparam int DW = 32;
  localparam int QW = 16;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state_r;
  logic [DW-1:0]      dvd_r;
  logic [QW:0]        dsr_r;
  logic [QW-1:0]      prem_r;
  logic [DW-1:0]      qmag_r;
  logic [4:0]         cnt_r;
  logic               neg_dvd_r;
  logic               neg_dsr_r;
  logic signed [QW-1:0] quotient_r;
  logic signed [QW-1:0] remainder_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic               ovf_r;

  logic [DW-1:0]      dvd_mag_s;
  logic [QW:0]        dsr_mag_s;
  logic [QW:0]        shifted_s;
  logic               ge_s;
  logic               qneg_s;
  logic               ovf_s;
  logic [QW-1:0]      qsgn_s;
  logic [QW-1:0]      rem_s;

  // Operand magnitudes; the extra divisor bit keeps |-32768| representable.
  always_comb begin
    dvd_mag_s = bus.dividend[DW-1] ? (32'd0 - $unsigned(bus.dividend)) : $unsigned(bus.dividend);
    dsr_mag_s = bus.divisor[QW-1] ? (17'd0 - {1'b1, $unsigned(bus.divisor)})
                                  : {1'b0, $unsigned(bus.divisor)};
  end

  // One restoring step plus the signed fix-up terms used in SIGN.
  always_comb begin
    shifted_s = {prem_r, dvd_r[DW-1]};
    ge_s      = (shifted_s >= dsr_r);
    qneg_s    = neg_dvd_r ^ neg_dsr_r;
    ovf_s     = qneg_s ? (qmag_r > 32'd32768) : (qmag_r > 32'd32767);
    qsgn_s    = qneg_s ? (16'd0 - qmag_r[QW-1:0]) : qmag_r[QW-1:0];
    rem_s     = neg_dvd_r ? (16'd0 - prem_r) : prem_r;
  end

  // Control FSM with registered results and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dvd_r       <= 32'd0;
      dsr_r       <= 17'd0;
      prem_r      <= 16'd0;
      qmag_r      <= 32'd0;
      cnt_r       <= 5'd0;
      neg_dvd_r   <= 1'b0;
      neg_dsr_r   <= 1'b0;
      quotient_r  <= 16'sd0;
      remainder_r <= 16'sd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= bus.start;
          if (bus.start) begin
            ovf_r <= 1'b0;
            if (bus.divisor == 16'sd0) begin
              dbz_r       <= 1'b1;
              quotient_r  <= 16'sd0;
              remainder_r <= bus.dividend[QW-1:0];
              state_r     <= DONE;
            end else begin
              dbz_r     <= 1'b0;
              dvd_r     <= dvd_mag_s;
              dsr_r     <= dsr_mag_s;
              neg_dvd_r <= bus.dividend[DW-1];
              neg_dsr_r <= bus.divisor[QW-1];
              prem_r    <= 16'd0;
              qmag_r    <= 32'd0;
              cnt_r     <= 5'd0;
              state_r   <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // The partial remainder stays below |divisor| <= 32768, so 16 bits hold it.
          prem_r <= ge_s ? 16'(shifted_s - dsr_r) : shifted_s[QW-1:0];
          qmag_r <= {qmag_r[DW-2:0], ge_s};
          dvd_r  <= {dvd_r[DW-2:0], 1'b0};
          cnt_r  <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= SIGN;
          end else begin
            state_r <= CALC;
          end
        end
        SIGN: begin
          ovf_r       <= ovf_s;
          quotient_r  <= ovf_s ? (qneg_s ? 16'h8000 : 16'h7FFF) : qsgn_s;
          remainder_r <= rem_s;
          state_r     <= DONE;
        end
        DONE: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
endmodule
